// File: rtl/hex_pkg.sv
// Shared types and segment constants for the time-shared 7-segment digit scheduler.
// Segment words are active-low, bit 6 = g ... bit 0 = a.
package hex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;

  // Hex digit 0..F to active-low segment pattern
  localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_decode
  import hex_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_LUT[digit];
  end

endmodule

// File: rtl/hex_digit_scheduler.sv
// Round-robin time-sharing of one 7-segment digit between NREQ requesters.
// Each grant shows the latched nibble for HOLD_CYCLES clocks, then blanks for GAP_CYCLES.
module hex_digit_scheduler
  import hex_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [4*NREQ-1:0]        val,
  output logic [NREQ-1:0]          grant,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner_id,
  output logic [SEG_W-1:0]         hex
);

  localparam int unsigned OW   = $clog2(NREQ);
  localparam int unsigned CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(NREQ - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     rr_q, rr_d;
  logic [OW-1:0]     owner_d;
  logic [3:0]        digit_q, digit_d;
  logic [NREQ-1:0]   grant_d;
  logic              done_d, busy_d, start;
  logic [SEG_W-1:0]  hex_d, seg_c;
  logic              any_req;
  logic [OW-1:0]     win_c;
  int unsigned       idx;

  // Round-robin pick: scan from rr_q upward; descending loop lets the earliest hit win
  always_comb begin
    win_c   = rr_q;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (32'(rr_q) + 32'(k)) % NREQ;
      if (req[idx]) begin
        win_c   = OW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Decode the value about to be latched so hex changes on the grant edge itself
  seg7_decode u_seg7_decode (
    .digit (digit_d),
    .seg_c (seg_c)
  );

  // Next state, counter, arbitration bookkeeping and next output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    owner_d = owner_id;
    digit_d = digit_q;
    start   = 1'b0;
    grant_d = '0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    hex_d   = SEG_ZERO;

    case (state_q)
      IDLE: begin
        if (any_req) start = 1'b1;
      end
      SHOW: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (any_req) start = 1'b1;
          else         state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SHOW;
      cnt_d   = HOLD_LOAD;
      owner_d = win_c;
      rr_d    = (win_c == LAST_IDX) ? '0 : win_c + 1'b1;
      digit_d = val[4*win_c +: 4];
    end

    busy_d = (state_d != IDLE);
    case (state_d)
      SHOW: begin
        grant_d[owner_d] = 1'b1;
        done_d           = (cnt_d == '0);
        hex_d            = seg_c;
      end
      GAP:     hex_d = SEG_BLANK;
      default: hex_d = SEG_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_q     <= '0;
      digit_q  <= '0;
      owner_id <= '0;
      grant    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      hex      <= SEG_ZERO;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      digit_q  <= digit_d;
      owner_id <= owner_d;
      grant    <= grant_d;
      done     <= done_d;
      busy     <= busy_d;
      hex      <= hex_d;
    end
  end

endmodule

// File: tb/tb_hex_digit_scheduler.sv
// Self-checking bench for hex_digit_scheduler: per-cycle scoreboard against a phase-counting
// reference model, plus a decode vector table and directed multi-cycle sequences.
module tb_hex_digit_scheduler;

  localparam int NREQ = 4;
  localparam int HOLD = 8;
  localparam int GAPC = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] val;
  logic [3:0]  grant;
  logic        done, busy;
  logic [1:0]  owner_id;
  logic [6:0]  hex;

  hex_digit_scheduler #(.NREQ(NREQ), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .val      (val),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .owner_id (owner_id),
    .hex      (hex)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic       done;
    logic       busy;
    logic [1:0] owner;
    logic [6:0] hex;
  } out_t;

  typedef struct {
    logic [3:0] d;
    logic [6:0] seg;
  } dvec_t;

  dvec_t dtab [16];
  out_t  sb_q [$];
  out_t  obs;
  int    checks = 0;
  int    errors = 0;

  // Reference model: 0 idle, 1 show, 2 gap; phase counts up from 1
  int         m_state, m_phase, m_owner, m_last;
  logic [3:0] m_digit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_pick(input logic [3:0] r, input logic [15:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (r[i]) begin
        m_owner = i;
        m_last  = i;
        m_digit = v[4*i +: 4];
        m_state = 1;
        m_phase = 1;
        return;
      end
    end
    m_state = 0;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] r, input logic [15:0] v);
    out_t e;
    if (rst) begin
      m_state = 0; m_phase = 0; m_owner = 0; m_last = NREQ - 1; m_digit = 4'h0;
    end else begin
      case (m_state)
        0: if (r != 4'b0) model_pick(r, v);
        1: if (m_phase == HOLD) begin m_state = 2; m_phase = 1; end
           else m_phase++;
        default: if (m_phase == GAPC) model_pick(r, v);
                 else m_phase++;
      endcase
    end
    e.grant = (m_state == 1) ? 4'(1 << m_owner) : 4'b0;
    e.done  = (m_state == 1) && (m_phase == HOLD);
    e.busy  = (m_state != 0);
    e.owner = 2'(m_owner);
    e.hex   = (m_state == 0) ? 7'b1000000 : (m_state == 2) ? 7'b1111111 : dtab[m_digit].seg;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic [3:0] r, input logic [15:0] v);
    out_t e;
    @(negedge clk);
    reset = rst; req = r; val = v;
    model_step(rst, r, v);
    @(posedge clk);
    #1;
    obs = '{grant: grant, done: done, busy: busy, owner: owner_id, hex: hex};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      if (obs !== e) begin
        errors++;
        $display("FAIL scoreboard at %0t: got g=%b d=%b b=%b o=%0d h=%b expected g=%b d=%b b=%b o=%0d h=%b",
                 $time, obs.grant, obs.done, obs.busy, obs.owner, obs.hex,
                 e.grant, e.done, e.busy, e.owner, e.hex);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] segs [16];
    int         own_exp [5];
    int         hex_idx [5];
    int         ndone;

    segs = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    for (int i = 0; i < 16; i++) dtab[i] = '{4'(i), segs[i]};
    own_exp = '{0, 1, 3, 0, 1};
    hex_idx = '{1, 2, 10, 1, 2};

    reset = 1'b1; req = '0; val = '0;

    // Reset with all requests pending
    cycle(1'b1, 4'b1111, 16'h0000);
    cycle(1'b1, 4'b1111, 16'h0000);
    chk("reset_hex", 32'(hex), 32'(7'b1000000));
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    cycle(1'b0, 4'b1111, 16'h0000);
    chk("first_grant", 32'(grant), 32'(4'b0001));
    chk("first_owner", 32'(owner_id), 32'h0);

    // Single requester with default timing
    cycle(1'b1, 4'b0000, 16'h0000);
    ndone = 0;
    for (int c = 0; c < HOLD; c++) begin
      cycle(1'b0, 4'b0100, 16'h0300);
      chk("single_hex", 32'(hex), 32'(7'b0110000));
      chk("single_grant", 32'(grant), 32'(4'b0100));
      if (done) ndone++;
    end
    chk("single_done_last", 32'(done), 32'h1);
    chk("single_done_count", 32'(ndone), 32'h1);
    cycle(1'b0, 4'b0100, 16'h0300);
    chk("single_gap_hex", 32'(hex), 32'(7'b1111111));
    cycle(1'b0, 4'b0100, 16'h0300);
    chk("single_reshow", 32'(grant), 32'(4'b0100));

    // Round-robin over requesters 0, 1, 3
    cycle(1'b1, 4'b0000, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'b1011, 16'hA021);
      chk("rr_owner", 32'(owner_id), 32'(own_exp[k]));
      chk("rr_hex", 32'(hex), 32'(dtab[hex_idx[k]].seg));
      repeat (HOLD - 1) cycle(1'b0, 4'b1011, 16'hA021);
      cycle(1'b0, 4'b1011, 16'hA021);
      chk("rr_gap", 32'(hex), 32'(7'b1111111));
    end

    // Value and request changes mid-SHOW are ignored
    cycle(1'b1, 4'b0000, 16'h0000);
    cycle(1'b0, 4'b0100, 16'h0500);
    cycle(1'b0, 4'b0100, 16'h0500);
    for (int c = 3; c <= HOLD; c++) cycle(1'b0, 4'b0000, 16'h0F00);
    chk("latch_hex", 32'(hex), 32'(7'b0010010));
    chk("latch_done", 32'(done), 32'h1);
    cycle(1'b0, 4'b0000, 16'h0F00);
    cycle(1'b0, 4'b0000, 16'h0F00);
    chk("idle_return_hex", 32'(hex), 32'(7'b1000000));
    chk("idle_return_busy", 32'(busy), 32'h0);

    // Reset during SHOW cycle 4
    cycle(1'b0, 4'b1111, 16'h1234);
    cycle(1'b0, 4'b0010, 16'h1234);
    cycle(1'b0, 4'b0010, 16'h1234);
    cycle(1'b1, 4'b1111, 16'h1234);
    chk("midreset_hex", 32'(hex), 32'(7'b1000000));
    chk("midreset_done", 32'(done), 32'h0);
    chk("midreset_busy", 32'(busy), 32'h0);
    cycle(1'b0, 4'b1111, 16'h1234);
    chk("midreset_rr", 32'(grant), 32'(4'b0001));

    // Exhaustive decode through sole requester 0, returning to IDLE each time
    cycle(1'b1, 4'b0000, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'b0001, {12'h000, dtab[i].d});
      chk("decode", 32'(hex), 32'(dtab[i].seg));
      repeat (HOLD) cycle(1'b0, 4'b0000, 16'h0000);
      cycle(1'b0, 4'b0000, 16'h0000);
    end
    chk("decode_idle_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
